pipe_controller: RTL and testbench

//  Pipelined control unit for the 5-stage ARM datapath. Decodes InstrD and generates
//  the Decode-stage controls. Carries the rest through D/E, E/M and M/W control

---
 rtl/pipe_ctrl_pkg.sv | 57 +++++
 rtl/pipe_controller_cond_check.sv | 40 ++++
 rtl/pipe_controller.sv | 197 +++++++++++++++++++
 tb/tb_pipe_controller.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipelined ARM control unit.
package pipe_ctrl_pkg;

  // ARM condition field encodings (instruction bits [31:28]).
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  // ALUControl encodings.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Instruction class (bits [27:26]).
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Data-processing cmd field (bits [24:21]) values the datapath supports.
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Controls carried from Decode into Execute.
  typedef struct packed {
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       branch;
    logic       pcs;
    logic       alu_src;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic [3:0] cond;
  } ctrl_de_t;

  // Controls carried from Execute into Memory (already condition-gated).
  typedef struct packed {
    logic reg_w;
    logic mem_w;
    logic mem_to_reg;
    logic pcs;
  } ctrl_em_t;

  // Controls carried from Memory into Writeback.
  typedef struct packed {
    logic reg_w;
    logic mem_to_reg;
    logic pcs;
  } ctrl_mw_t;

endpackage

// File: rtl/pipe_controller_cond_check.sv
// Condition evaluator: decides whether the instruction in Execute runs,
// given its cond field and the architectural NZCV flags.
module cond_check
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n_flag, z_flag, c_flag, v_flag;
  logic ge;

  assign {n_flag, z_flag, c_flag, v_flag} = flags;
  assign ge = (n_flag == v_flag);

  // Evaluate the ARM condition table against the current flags.
  always_comb begin
    condex = 1'b0;
    case (cond_t'(cond))
      COND_EQ: condex = z_flag;
      COND_NE: condex = ~z_flag;
      COND_CS: condex = c_flag;
      COND_CC: condex = ~c_flag;
      COND_MI: condex = n_flag;
      COND_PL: condex = ~n_flag;
      COND_VS: condex = v_flag;
      COND_VC: condex = ~v_flag;
      COND_HI: condex = c_flag & ~z_flag;
      COND_LS: condex = ~c_flag | z_flag;
      COND_GE: condex = ge;
      COND_LT: condex = ~ge;
      COND_GT: condex = ~z_flag & ge;
      COND_LE: condex = z_flag | ~ge;
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit for the 5-stage ARM datapath.
// Decodes InstrD, carries controls through D/E, E/M and M/W registers,
// owns the NZCV flag register and resolves conditional execution in Execute.
// Build option COND_EXEC_EN: when defined, instructions are gated by their
// cond field; when undefined every instruction executes as AL.
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 2,
  parameter int FLAG_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          InstrD,
  input  logic [FLAG_W-1:0]    ALUFlagsE,
  input  logic                 FlushE,
  output logic [1:0]           RegSrcD,
  output logic [1:0]           ImmSrcD,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 MemWriteM,
  output logic                 MemtoRegW,
  output logic                 RegWriteW,
  output logic                 PCSrcW,
  output logic                 BranchTakenE,
  output logic [FLAG_W-1:0]    FlagsQ
);

  logic [1:0] op;
  logic       funct_i_bit;
  logic [3:0] cmd;
  logic       funct_s_bit;
  logic [3:0] rd;

  ctrl_de_t dec_d;
  ctrl_de_t de_d, de_q;
  ctrl_em_t em_d, em_q;
  ctrl_mw_t mw_d, mw_q;
  logic [FLAG_W-1:0] flags_d, flags_q;
  logic cond_ex_e;

  assign op          = InstrD[27:26];
  assign funct_i_bit = InstrD[25];
  assign cmd         = InstrD[24:21];
  assign funct_s_bit = InstrD[20];
  assign rd          = InstrD[15:12];

  // Register-number and offset fields belong to the datapath, not to control.
  logic instr_unused;
  assign instr_unused = ^{InstrD[19:16], InstrD[11:0]};

  // Decode InstrD into Decode-stage selects and the controls for D/E.
  always_comb begin
    RegSrcD = 2'b00;
    ImmSrcD = 2'b00;
    dec_d   = '0;
    dec_d.cond = InstrD[31:28];
    case (op)
      OP_DP: begin
        dec_d.alu_src = funct_i_bit;
        case (cmd)
          CMD_ADD: begin
            dec_d.reg_w       = 1'b1;
            dec_d.alu_control = ALU_ADD;
            dec_d.flag_w      = {funct_s_bit, funct_s_bit};
          end
          CMD_SUB: begin
            dec_d.reg_w       = 1'b1;
            dec_d.alu_control = ALU_SUB;
            dec_d.flag_w      = {funct_s_bit, funct_s_bit};
          end
          CMD_AND: begin
            dec_d.reg_w       = 1'b1;
            dec_d.alu_control = ALU_AND;
            dec_d.flag_w      = {funct_s_bit, 1'b0};
          end
          CMD_ORR: begin
            dec_d.reg_w       = 1'b1;
            dec_d.alu_control = ALU_ORR;
            dec_d.flag_w      = {funct_s_bit, 1'b0};
          end
          default: begin
            // Unsupported data-processing command: behaves as a NOP.
            dec_d.reg_w  = 1'b0;
            dec_d.flag_w = 2'b00;
          end
        endcase
      end
      OP_MEM: begin
        ImmSrcD       = 2'b01;
        dec_d.alu_src = 1'b1;
        if (funct_s_bit) begin
          // LDR
          RegSrcD          = 2'b00;
          dec_d.mem_to_reg = 1'b1;
          dec_d.reg_w      = 1'b1;
        end else begin
          // STR reads Rd as the store data, hence RegSrc[1].
          RegSrcD     = 2'b10;
          dec_d.mem_w = 1'b1;
        end
      end
      OP_BR: begin
        RegSrcD       = 2'b01;
        ImmSrcD       = 2'b10;
        dec_d.alu_src = 1'b1;
        dec_d.branch  = 1'b1;
      end
      default: begin
        // op 11: no architectural effect.
        dec_d.reg_w = 1'b0;
      end
    endcase
    dec_d.pcs = ((rd == 4'hF) & dec_d.reg_w) | dec_d.branch;
  end

  // Turn the incoming instruction into a bubble when Execute is flushed.
  always_comb begin
    de_d = dec_d;
    if (FlushE) begin
      de_d.reg_w  = 1'b0;
      de_d.mem_w  = 1'b0;
      de_d.branch = 1'b0;
      de_d.pcs    = 1'b0;
      de_d.flag_w = 2'b00;
    end
  end

  // D/E control register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) de_q <= '0;
    else        de_q <= de_d;
  end

`ifdef COND_EXEC_EN
  cond_check u_cond_check (
    .cond   (de_q.cond),
    .flags  (flags_q),
    .condex (cond_ex_e)
  );
`else
  // Without conditional execution the cond field has no effect.
  logic cond_unused;
  assign cond_unused = ^de_q.cond;
  assign cond_ex_e   = 1'b1;
`endif

  // Next flags: N,Z and C,V update independently, only if the instruction runs.
  always_comb begin
    flags_d = flags_q;
    if (de_q.flag_w[1] & cond_ex_e) flags_d[3:2] = ALUFlagsE[3:2];
    if (de_q.flag_w[0] & cond_ex_e) flags_d[1:0] = ALUFlagsE[1:0];
  end

  // Architectural NZCV register; written at the end of the writer's Execute cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  // Gate side-effecting controls with the Execute-stage condition result.
  always_comb begin
    em_d.reg_w      = de_q.reg_w & cond_ex_e;
    em_d.mem_w      = de_q.mem_w & cond_ex_e;
    em_d.mem_to_reg = de_q.mem_to_reg;
    em_d.pcs        = de_q.pcs & cond_ex_e;
  end

  // E/M control register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) em_q <= '0;
    else        em_q <= em_d;
  end

  // M/W fields are forwarded unchanged from E/M.
  always_comb begin
    mw_d.reg_w      = em_q.reg_w;
    mw_d.mem_to_reg = em_q.mem_to_reg;
    mw_d.pcs        = em_q.pcs;
  end

  // M/W control register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mw_q <= '0;
    else        mw_q <= mw_d;
  end

  assign ALUSrcE      = de_q.alu_src;
  assign ALUControlE  = de_q.alu_control;
  assign BranchTakenE = de_q.branch & cond_ex_e;
  assign MemWriteM    = em_q.mem_w;
  assign MemtoRegW    = mw_q.mem_to_reg;
  assign RegWriteW    = mw_q.reg_w;
  assign PCSrcW       = mw_q.pcs;
  assign FlagsQ       = flags_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: directed scenarios followed by
// random instruction streams, checked against an instruction-level model
// that tracks each issued instruction by its age in the pipeline.
module tb_pipe_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] InstrD = 32'h0;
  logic [3:0]  ALUFlagsE = 4'h0;
  logic        FlushE = 1'b0;
  logic [1:0]  RegSrcD, ImmSrcD, ALUControlE;
  logic        ALUSrcE, MemWriteM, MemtoRegW, RegWriteW, PCSrcW, BranchTakenE;
  logic [3:0]  FlagsQ;

  pipe_controller dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE),
    .FlushE(FlushE), .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .MemWriteM(MemWriteM), .MemtoRegW(MemtoRegW),
    .RegWriteW(RegWriteW), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .FlagsQ(FlagsQ)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_NOP  = 32'hEC000000;
  localparam logic [31:0] I_ADD  = 32'hE0821003;
  localparam logic [31:0] I_SUBS = 32'hE0500000;
  localparam logic [31:0] I_ADDS = 32'hE0911003;
  localparam logic [31:0] I_BEQ  = 32'h0A000001;
  localparam logic [31:0] I_BNE  = 32'h1A000001;
  localparam logic [31:0] I_STR  = 32'hE5801000;
  localparam logic [31:0] I_STRN = 32'h15801000;
  localparam logic [31:0] I_LDR  = 32'hE5912000;

`ifdef COND_EXEC_EN
  localparam bit NE_WHEN_Z = 1'b0;
`else
  localparam bit NE_WHEN_Z = 1'b1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Expected behaviour of one instruction, straight from the decode rules.
  typedef struct {
    bit       regw, memw, mtr, branch, pcs, alusrc;
    bit [1:0] aluctl, flagw, regsrc, immsrc;
    bit [3:0] cond;
    bit       rs_chk, is_chk, as_chk, ac_chk;
  } ref_t;

  typedef struct {
    ref_t d;
    bit   bub;
    bit   cx;
    int   age;
  } rec_t;

  rec_t     pipe_q[$];
  bit [3:0] flags_m = 4'h0;

  function automatic ref_t ref_decode(input bit [31:0] ins);
    ref_t r;
    bit [1:0] op  = ins[27:26];
    bit       ib  = ins[25];
    bit [3:0] cmd = ins[24:21];
    bit       s   = ins[20];
    r = '{default: 0};
    r.cond = ins[31:28];
    case (op)
      2'd0: begin
        r.rs_chk = 1; r.regsrc = 2'b00;
        r.is_chk = ib; r.immsrc = 2'b00;
        r.as_chk = 1; r.alusrc = ib;
        case (cmd)
          4'b0100: begin r.ac_chk = 1; r.aluctl = 2'b00; r.regw = 1; r.flagw = {s, s};    end
          4'b0010: begin r.ac_chk = 1; r.aluctl = 2'b01; r.regw = 1; r.flagw = {s, s};    end
          4'b0000: begin r.ac_chk = 1; r.aluctl = 2'b10; r.regw = 1; r.flagw = {s, 1'b0}; end
          4'b1100: begin r.ac_chk = 1; r.aluctl = 2'b11; r.regw = 1; r.flagw = {s, 1'b0}; end
          default: ;
        endcase
      end
      2'd1: begin
        r.rs_chk = 1; r.is_chk = 1; r.immsrc = 2'b01;
        r.as_chk = 1; r.alusrc = 1; r.ac_chk = 1; r.aluctl = 2'b00;
        if (s) begin r.regsrc = 2'b00; r.mtr = 1; r.regw = 1; end
        else   begin r.regsrc = 2'b10; r.memw = 1; end
      end
      2'd2: begin
        r.rs_chk = 1; r.regsrc = 2'b01; r.is_chk = 1; r.immsrc = 2'b10;
        r.as_chk = 1; r.alusrc = 1; r.ac_chk = 1; r.aluctl = 2'b00; r.branch = 1;
      end
      default: begin
        r.ac_chk = 1; r.aluctl = 2'b00;
      end
    endcase
    r.pcs = (ins[15:12] == 4'hF && r.regw) || r.branch;
    return r;
  endfunction

  function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] f);
`ifdef COND_EXEC_EN
    bit n = f[3], z = f[2], cf = f[1], v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (c == c);
`endif
  endfunction

  // One pipeline cycle: present an instruction in Decode, check every output
  // against the instructions currently 1, 2 and 3 cycles old, then advance.
  task automatic step(input bit [31:0] ins, input bit fl, input bit [3:0] af);
    ref_t d = ref_decode(ins);
    rec_t nr;
    int ie = -1, im = -1, iw = -1;
    bit cx = 1'b0;
    @(negedge clk);
    InstrD = ins; FlushE = fl; ALUFlagsE = af;
    #1;
    if (d.rs_chk) chk("RegSrcD", RegSrcD, d.regsrc);
    if (d.is_chk) chk("ImmSrcD", ImmSrcD, d.immsrc);
    foreach (pipe_q[k]) begin
      if (pipe_q[k].age == 1) ie = k;
      if (pipe_q[k].age == 2) im = k;
      if (pipe_q[k].age == 3) iw = k;
    end
    if (ie >= 0) begin
      cx = cond_ok(pipe_q[ie].d.cond, flags_m);
      pipe_q[ie].cx = cx;
      if (!pipe_q[ie].bub && pipe_q[ie].d.as_chk) chk("ALUSrcE", ALUSrcE, pipe_q[ie].d.alusrc);
      if (!pipe_q[ie].bub && pipe_q[ie].d.ac_chk) chk("ALUControlE", ALUControlE, pipe_q[ie].d.aluctl);
      chk("BranchTakenE", BranchTakenE, pipe_q[ie].d.branch & cx);
    end else begin
      chk("ALUSrcE_empty", ALUSrcE, 0);
      chk("ALUControlE_empty", ALUControlE, 0);
      chk("BranchTakenE_empty", BranchTakenE, 0);
    end
    chk("FlagsQ", FlagsQ, flags_m);
    if (im >= 0) chk("MemWriteM", MemWriteM, pipe_q[im].d.memw & pipe_q[im].cx);
    else         chk("MemWriteM_empty", MemWriteM, 0);
    if (iw >= 0) begin
      chk("RegWriteW", RegWriteW, pipe_q[iw].d.regw & pipe_q[iw].cx);
      chk("PCSrcW", PCSrcW, pipe_q[iw].d.pcs & pipe_q[iw].cx);
      if (!pipe_q[iw].bub) chk("MemtoRegW", MemtoRegW, pipe_q[iw].d.mtr);
    end else begin
      chk("RegWriteW_empty", RegWriteW, 0);
      chk("PCSrcW_empty", PCSrcW, 0);
      chk("MemtoRegW_empty", MemtoRegW, 0);
    end
    // Flag write by the instruction in Execute lands at the coming edge.
    if (ie >= 0 && cx) begin
      if (pipe_q[ie].d.flagw[1]) flags_m[3:2] = af[3:2];
      if (pipe_q[ie].d.flagw[0]) flags_m[1:0] = af[1:0];
    end
    nr.d = d; nr.bub = fl; nr.cx = 1'b0; nr.age = 0;
    if (fl) begin
      nr.d.regw = 0; nr.d.memw = 0; nr.d.branch = 0; nr.d.pcs = 0; nr.d.flagw = 0;
    end
    pipe_q.push_back(nr);
    foreach (pipe_q[k]) pipe_q[k].age++;
    while (pipe_q.size() > 0 && pipe_q[0].age > 3) void'(pipe_q.pop_front());
    $display("cyc %0d instr %08h flush %0d aluflags %04b flagsQ %04b", cyc, ins, fl, af, FlagsQ);
    cyc++;
  endtask

  task automatic check_reset_outs(input string tag);
    ref_t d = ref_decode(InstrD);
    chk({tag, "_ALUSrcE"}, ALUSrcE, 0);
    chk({tag, "_ALUControlE"}, ALUControlE, 0);
    chk({tag, "_BranchTakenE"}, BranchTakenE, 0);
    chk({tag, "_MemWriteM"}, MemWriteM, 0);
    chk({tag, "_MemtoRegW"}, MemtoRegW, 0);
    chk({tag, "_RegWriteW"}, RegWriteW, 0);
    chk({tag, "_PCSrcW"}, PCSrcW, 0);
    chk({tag, "_FlagsQ"}, FlagsQ, 0);
    if (d.rs_chk) chk({tag, "_RegSrcD"}, RegSrcD, d.regsrc);
    if (d.is_chk) chk({tag, "_ImmSrcD"}, ImmSrcD, d.immsrc);
    $display("cyc %0d reset held, instr %08h", cyc, InstrD);
  endtask

  // Assert reset mid-cycle with garbage inputs, hold it, release away from the edge.
  task automatic hold_reset(input int ncyc);
    @(negedge clk);
    #2;
    reset = 1'b0;
    InstrD = $urandom; FlushE = 1'($urandom); ALUFlagsE = 4'($urandom);
    pipe_q.delete();
    flags_m = 4'h0;
    #1;
    check_reset_outs("rst_async");
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      InstrD = $urandom; ALUFlagsE = 4'($urandom);
      #1;
      check_reset_outs("rst_hold");
      cyc++;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  function automatic bit [31:0] rand_instr();
    bit [31:0] ins = $urandom;
    bit [3:0]  cmds [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
    if ($urandom_range(1, 0) == 1) ins[31:28] = 4'hE;
    if (ins[27:26] == 2'b00 && $urandom_range(1, 0) == 1) ins[24:21] = cmds[$urandom_range(3, 0)];
    if ($urandom_range(7, 0) == 0) ins[15:12] = 4'hF;
    return ins;
  endfunction

  initial begin
    // 1: reset with garbage inputs, held 3 cycles.
    hold_reset(3);

    // 2: ADD R1,R2,R3.
    step(I_ADD, 0, 4'h0);
    step(I_NOP, 0, 4'h0);
    chk("t2_ALUControlE", ALUControlE, 2'b00);
    step(I_NOP, 0, 4'h0);
    step(I_NOP, 0, 4'h0);
    chk("t2_RegWriteW", RegWriteW, 1);
    chk("t2_MemtoRegW", MemtoRegW, 0);
    chk("t2_PCSrcW", PCSrcW, 0);

    // 3: SUBS sets Z, then BEQ and BNE.
    step(I_SUBS, 0, 4'h0);
    step(I_BEQ, 0, 4'b0110);
    step(I_NOP, 0, 4'h0);
    chk("t3_FlagsQ", FlagsQ, 4'b0110);
    chk("t3_beq_taken", BranchTakenE, 1);
    step(I_NOP, 0, 4'h0);
    step(I_NOP, 0, 4'h0);
    chk("t3_beq_PCSrcW", PCSrcW, 1);
    step(I_BNE, 0, 4'h0);
    step(I_NOP, 0, 4'h0);
    chk("t3_bne_taken", BranchTakenE, NE_WHEN_Z);
    step(I_NOP, 0, 4'h0);
    step(I_NOP, 0, 4'h0);
    chk("t3_bne_PCSrcW", PCSrcW, NE_WHEN_Z);

    // 4: STR, unconditional then under NE with Z=1.
    step(I_STR, 0, 4'h0);
    chk("t4_ImmSrcD", ImmSrcD, 2'b01);
    chk("t4_RegSrcD", RegSrcD, 2'b10);
    step(I_NOP, 0, 4'h0);
    step(I_NOP, 0, 4'h0);
    chk("t4_MemWriteM", MemWriteM, 1);
    step(I_NOP, 0, 4'h0);
    chk("t4_RegWriteW", RegWriteW, 0);
    step(I_STRN, 0, 4'h0);
    step(I_NOP, 0, 4'h0);
    step(I_NOP, 0, 4'h0);
    chk("t4_strne_MemWriteM", MemWriteM, NE_WHEN_Z);

    // 5: flushed LDR while the preceding ADDS writes flags.
    step(I_ADDS, 0, 4'h0);
    step(I_LDR, 1, 4'b1010);
    step(I_NOP, 0, 4'h0);
    chk("t5_FlagsQ", FlagsQ, 4'b1010);
    step(I_NOP, 0, 4'h0);
    step(I_NOP, 0, 4'h0);
    chk("t5_RegWriteW", RegWriteW, 0);

    // 6: reset with three instructions in flight leaves no write pulses.
    step(I_ADD, 0, 4'h0);
    step(I_STR, 0, 4'h0);
    step(I_LDR, 0, 4'h0);
    hold_reset(2);
    for (int i = 0; i < 4; i++) begin
      step(I_NOP, 0, 4'h0);
      chk("t6_RegWriteW", RegWriteW, 0);
      chk("t6_MemWriteM", MemWriteM, 0);
    end

    // Random streams with flushes, and one reset in the middle.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) hold_reset(1);
      step(rand_instr(), ($urandom_range(4, 0) == 0), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
